// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parser_pkg
// Purpose  : Shared definitions for the parser / head-shift pipeline:
//            slice tag bit positions, shift field width, default shift
//            limits, the shift command record and the scheduler state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package parser_pkg;

  // Positions of the framing bits inside a slice tag word.
  localparam int TAG_VALID_BIT = 0;
  localparam int TAG_START_BIT = 1;
  localparam int TAG_TAIL_BIT  = 2;

  // Width of one shift field and the default largest legal shift amounts.
  localparam int SHIFT_WIDTH      = 4;
  localparam int C_HEAD_CANDI_NUM = 8;
  localparam int C_META_CANDI_NUM = 8;

  typedef struct packed {
    logic [SHIFT_WIDTH-1:0] head_shift;
    logic [SHIFT_WIDTH-1:0] meta_shift;
  } shift_cmd_t;

  typedef enum logic {
    SCH_IDLE   = 1'b0,
    SCH_IN_PKT = 1'b1
  } sch_state_e;

endpackage : parser_pkg
`default_nettype wire

// File: rtl/shift_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : shift_cmd_fifo
// Purpose  : First-word-fall-through FIFO holding pending shift commands.
//            The head entry is visible on o_data whenever o_empty is low.
//            Push and pop may occur in the same cycle; there is no bypass,
//            so a pushed word becomes visible the cycle after the push.
// Ports    : i_clk, i_rst (async, active-high)
//            i_push / i_data  - write port (caller guarantees !o_full)
//            i_pop            - consume head entry (caller guarantees !o_empty)
//            o_data           - head entry
//            o_full, o_empty  - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module shift_cmd_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (i_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule : shift_cmd_fifo
`default_nettype wire

// File: rtl/head_shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : head_shift_sched
// Purpose  : Per-packet scheduler for the head/meta shift stage. Queues
//            shift commands and presents the oldest one to the shift stage
//            on the cycle a start slice is transferred. Start slices stall
//            while no command is queued. Tracks packet framing, counts
//            slices and completed packets, and flags protocol errors.
// Ports    : i_clk, i_rst (async, active-high)
//            i_cmd_valid / o_cmd_ready / i_cmd_headShift / i_cmd_metaShift
//                             - shift command push interface
//            i_slc_valid / i_slc_start / i_slc_tail / o_slc_ready
//                             - slice handshake at the shift-stage input
//            i_dn_ready       - shift stage can take a slice
//            o_slc_fire       - slice transferred this cycle
//            o_headShift / o_metaShift - shift amounts for the shift stage
//            o_in_pkt, o_slc_cnt, o_pkt_cnt - framing status (registered)
//            o_err            - sticky: [0] clamp, [1] start w/o tail,
//                               [2] slice outside packet
// Revision : 1.0 - initial release
// ============================================================================
module head_shift_sched
  import parser_pkg::*;
#(
  parameter int HEAD_CANDI_NUM   = C_HEAD_CANDI_NUM,
  parameter int META_CANDI_NUM   = C_META_CANDI_NUM,
  parameter int HEAD_SHIFT_WIDTH = SHIFT_WIDTH,
  parameter int META_SHIFT_WIDTH = SHIFT_WIDTH,
  parameter int CMD_DEPTH        = 4,
  parameter int SLICE_CNT_WIDTH  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [HEAD_SHIFT_WIDTH-1:0] i_cmd_headShift,
  input  logic [META_SHIFT_WIDTH-1:0] i_cmd_metaShift,
  input  logic                        i_slc_valid,
  input  logic                        i_slc_start,
  input  logic                        i_slc_tail,
  output logic                        o_slc_ready,
  input  logic                        i_dn_ready,
  output logic                        o_slc_fire,
  output logic [HEAD_SHIFT_WIDTH-1:0] o_headShift,
  output logic [META_SHIFT_WIDTH-1:0] o_metaShift,
  output logic                        o_in_pkt,
  output logic [SLICE_CNT_WIDTH-1:0]  o_slc_cnt,
  output logic [15:0]                 o_pkt_cnt,
  output logic [2:0]                  o_err
);

  localparam int CMD_W = HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
  localparam logic [HEAD_SHIFT_WIDTH-1:0] C_HEAD_MAX = HEAD_SHIFT_WIDTH'(HEAD_CANDI_NUM);
  localparam logic [META_SHIFT_WIDTH-1:0] C_META_MAX = META_SHIFT_WIDTH'(META_CANDI_NUM);
  localparam logic [SLICE_CNT_WIDTH-1:0]  C_SLC_ONE  = SLICE_CNT_WIDTH'(1);

  // ---------------------------------------------------------------- command path
  logic                        w_full, w_empty, w_push, w_pop;
  logic                        w_head_over, w_meta_over, w_clamp;
  logic [HEAD_SHIFT_WIDTH-1:0] w_head_in, w_head_out;
  logic [META_SHIFT_WIDTH-1:0] w_meta_in, w_meta_out;
  logic [CMD_W-1:0]            w_fifo_out;

  assign w_push      = i_cmd_valid & ~w_full;
  assign w_head_over = int'(i_cmd_headShift) > HEAD_CANDI_NUM;
  assign w_meta_over = int'(i_cmd_metaShift) > META_CANDI_NUM;
  assign w_head_in   = w_head_over ? C_HEAD_MAX : i_cmd_headShift;
  assign w_meta_in   = w_meta_over ? C_META_MAX : i_cmd_metaShift;
  assign w_clamp     = w_push & (w_head_over | w_meta_over);

  shift_cmd_fifo #(
    .DATA_W (CMD_W),
    .DEPTH  (CMD_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  ({w_head_in, w_meta_in}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_out, w_meta_out} = w_fifo_out;

  // Shift amounts are combinational so the shift stage sees them on the
  // very cycle it samples the start slice.
  assign o_headShift = w_empty ? '0 : w_head_out;
  assign o_metaShift = w_empty ? '0 : w_meta_out;
  assign o_cmd_ready = ~w_full;

  // ------------------------------------------------------------------ slice path
  // Only start slices wait for a command; body/tail slices need no binding.
  logic w_fire;
  assign o_slc_ready = i_dn_ready & ~(i_slc_start & w_empty);
  assign w_fire      = i_slc_valid & o_slc_ready;
  assign w_pop       = w_fire & i_slc_start;
  assign o_slc_fire  = w_fire;

  // ------------------------------------------------------------------- framing
  sch_state_e                 state_q, state_d;
  logic [SLICE_CNT_WIDTH-1:0] slc_cnt_q, slc_cnt_d;
  logic [15:0]                pkt_cnt_q, pkt_cnt_d;
  logic [2:0]                 err_q, err_d;

  always_comb begin
    state_d   = state_q;
    slc_cnt_d = slc_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q | {2'b00, w_clamp};
    case (state_q)
      SCH_IDLE: begin
        if (w_fire) begin
          if (i_slc_start) begin
            slc_cnt_d = C_SLC_ONE;
            if (i_slc_tail) pkt_cnt_d = pkt_cnt_q + 16'd1;
            else            state_d   = SCH_IN_PKT;
          end else begin
            // Stray slice: forwarded untouched, only flagged.
            err_d[2] = 1'b1;
          end
        end
      end
      SCH_IN_PKT: begin
        if (w_fire) begin
          if (i_slc_start) begin
            // Missing tail: abandon the old packet and open a new one.
            err_d[1]  = 1'b1;
            slc_cnt_d = C_SLC_ONE;
            if (i_slc_tail) begin
              pkt_cnt_d = pkt_cnt_q + 16'd1;
              state_d   = SCH_IDLE;
            end
          end else begin
            if (slc_cnt_q != '1) slc_cnt_d = slc_cnt_q + C_SLC_ONE;
            if (i_slc_tail) begin
              pkt_cnt_d = pkt_cnt_q + 16'd1;
              state_d   = SCH_IDLE;
            end
          end
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= SCH_IDLE;
      slc_cnt_q <= '0;
      pkt_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      slc_cnt_q <= slc_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

  assign o_in_pkt  = (state_q == SCH_IN_PKT);
  assign o_slc_cnt = slc_cnt_q;
  assign o_pkt_cnt = pkt_cnt_q;
  assign o_err     = err_q;

endmodule : head_shift_sched
`default_nettype wire

// File: tb/tb_head_shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_head_shift_sched
// Purpose  : Directed self-checking bench for head_shift_sched. Accepted
//            commands are clamped by the bench and queued; each transferred
//            start slice pops the queue and is compared against the shift
//            outputs. Framing counters and error flags are checked by value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_head_shift_sched;

  typedef struct {
    logic [3:0] h;
    logic [3:0] m;
  } exp_cmd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_h, cmd_m;
  logic       slc_valid, slc_start, slc_tail, slc_ready;
  logic       dn_ready, slc_fire;
  logic [3:0] head_shift, meta_shift;
  logic       in_pkt;
  logic [7:0] slc_cnt;
  logic [15:0] pkt_cnt;
  logic [2:0] err;

  int total = 0;
  int bad   = 0;
  exp_cmd_t sb[$];

  always #5 clk = ~clk;

  head_shift_sched #(
    .HEAD_CANDI_NUM   (8),
    .META_CANDI_NUM   (8),
    .HEAD_SHIFT_WIDTH (4),
    .META_SHIFT_WIDTH (4),
    .CMD_DEPTH        (4),
    .SLICE_CNT_WIDTH  (8)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_headShift (cmd_h),
    .i_cmd_metaShift (cmd_m),
    .i_slc_valid     (slc_valid),
    .i_slc_start     (slc_start),
    .i_slc_tail      (slc_tail),
    .o_slc_ready     (slc_ready),
    .i_dn_ready      (dn_ready),
    .o_slc_fire      (slc_fire),
    .o_headShift     (head_shift),
    .o_metaShift     (meta_shift),
    .o_in_pkt        (in_pkt),
    .o_slc_cnt       (slc_cnt),
    .o_pkt_cnt       (pkt_cnt),
    .o_err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns one time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] clamp8(input logic [3:0] v);
    return (v > 4'd8) ? 4'd8 : v;
  endfunction

  task automatic push(input logic [3:0] h, input logic [3:0] m, input logic exp_ready);
    exp_cmd_t e;
    cmd_valid = 1'b1;
    cmd_h     = h;
    cmd_m     = m;
    #1;
    chk("cmd_ready", cmd_ready, exp_ready);
    if (exp_ready) begin
      e.h = clamp8(h);
      e.m = clamp8(m);
      sb.push_back(e);
    end
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic check_shift();
    exp_cmd_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("head_shift", head_shift, e.h);
      chk("meta_shift", meta_shift, e.m);
    end
  endtask

  task automatic slice(input logic s, input logic t, input logic exp_fire);
    slc_valid = 1'b1;
    slc_start = s;
    slc_tail  = t;
    #1;
    chk("slc_fire", slc_fire, exp_fire);
    if (exp_fire && s) check_shift();
    cyc();
    slc_valid = 1'b0;
    slc_start = 1'b0;
    slc_tail  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_h = '0; cmd_m = '0;
    slc_valid = 1'b0; slc_start = 1'b0; slc_tail = 1'b0; dn_ready = 1'b1;
    cyc(); cyc();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_head", head_shift, 0);
    chk("rst_meta", meta_shift, 0);
    chk("rst_in_pkt", in_pkt, 0);
    chk("rst_slc_cnt", slc_cnt, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    cyc();

    // 1: one command, 4-slice packet
    push(4'd3, 4'd2, 1'b1);
    slice(1'b1, 1'b0, 1'b1);
    chk("t1_cnt1", slc_cnt, 1); chk("t1_in_pkt", in_pkt, 1);
    slice(1'b0, 1'b0, 1'b1); chk("t1_cnt2", slc_cnt, 2);
    slice(1'b0, 1'b0, 1'b1); chk("t1_cnt3", slc_cnt, 3);
    slice(1'b0, 1'b1, 1'b1);
    chk("t1_cnt4", slc_cnt, 4); chk("t1_pkt", pkt_cnt, 1); chk("t1_idle", in_pkt, 0);
    chk("t1_empty_head", head_shift, 0);

    // 2: start slice stalls until a command arrives
    slc_valid = 1'b1; slc_start = 1'b1; slc_tail = 1'b1;
    #1; chk("t2_stall0", slc_ready, 0);
    cyc(); chk("t2_stall1", slc_ready, 0);
    cmd_valid = 1'b1; cmd_h = 4'd5; cmd_m = 4'd1;
    #1; chk("t2_stall2", slc_ready, 0); chk("t2_cmd_ready", cmd_ready, 1);
    sb.push_back('{h: 4'd5, m: 4'd1});
    cyc(); cmd_valid = 1'b0;
    #1; chk("t2_ready", slc_ready, 1); chk("t2_fire", slc_fire, 1);
    check_shift();
    cyc(); slc_valid = 1'b0; slc_start = 1'b0; slc_tail = 1'b0;
    chk("t2_pkt", pkt_cnt, 2);

    // 3: fill the FIFO, fifth push refused, drain with one-slice packets
    push(4'd1, 4'd7, 1'b1);
    push(4'd2, 4'd6, 1'b1);
    push(4'd3, 4'd5, 1'b1);
    push(4'd4, 4'd4, 1'b1);
    push(4'd6, 4'd6, 1'b0);
    slice(1'b1, 1'b1, 1'b1);
    chk("t3_ready_back", cmd_ready, 1); chk("t3_pkt", pkt_cnt, 3);
    for (int i = 0; i < 3; i++) slice(1'b1, 1'b1, 1'b1);
    chk("t3_pkt_drain", pkt_cnt, 6); chk("t3_err", err, 0);

    // 4: out-of-range shift clamped
    push(4'd12, 4'd9, 1'b1);
    chk("t4_err", err, 3'b001);
    slice(1'b1, 1'b1, 1'b1);
    chk("t4_pkt", pkt_cnt, 7);

    // 5: start, start (missing tail), tail
    push(4'd1, 4'd1, 1'b1);
    push(4'd2, 4'd2, 1'b1);
    slice(1'b1, 1'b0, 1'b1);
    slice(1'b1, 1'b0, 1'b1);
    chk("t5_err", err, 3'b011); chk("t5_cnt_restart", slc_cnt, 1); chk("t5_in_pkt", in_pkt, 1);
    slice(1'b0, 1'b1, 1'b1);
    chk("t5_cnt", slc_cnt, 2); chk("t5_pkt", pkt_cnt, 8); chk("t5_idle", in_pkt, 0);

    // Slice outside any packet
    slice(1'b0, 1'b0, 1'b1);
    chk("stray_err", err, 3'b111); chk("stray_cnt", slc_cnt, 2); chk("stray_pkt", pkt_cnt, 8);

    // Slice counter saturation
    push(4'd7, 4'd7, 1'b1);
    slice(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) slice(1'b0, 1'b0, 1'b1);
    chk("sat_cnt", slc_cnt, 8'hFF);
    slice(1'b0, 1'b1, 1'b1);
    chk("sat_cnt_tail", slc_cnt, 8'hFF); chk("sat_pkt", pkt_cnt, 9);

    // Downstream backpressure blocks every slice
    dn_ready = 1'b0;
    slc_valid = 1'b1;
    #1; chk("bp_ready", slc_ready, 0); chk("bp_fire", slc_fire, 0);
    cyc(); slc_valid = 1'b0; dn_ready = 1'b1;
    chk("bp_pkt", pkt_cnt, 9);

    // 6: async reset mid-packet with two commands queued
    push(4'd4, 4'd4, 1'b1);
    push(4'd6, 4'd6, 1'b1);
    push(4'd2, 4'd3, 1'b1);
    slice(1'b1, 1'b0, 1'b1);
    chk("t6_in_pkt", in_pkt, 1);
    rst = 1'b1;
    #1;
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_head", head_shift, 0);
    chk("t6_in_pkt_rst", in_pkt, 0);
    chk("t6_slc_cnt", slc_cnt, 0);
    chk("t6_pkt_cnt", pkt_cnt, 0);
    chk("t6_err", err, 0);
    sb.delete();
    cyc();
    rst = 1'b0;
    slc_valid = 1'b1; slc_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("t6_stall", slc_ready, 0);
      cyc();
    end
    slc_valid = 1'b0; slc_start = 1'b0;
    chk("t6_pkt_after", pkt_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_head_shift_sched
`default_nettype wire
